// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, parity modes and baud divider helper for the
//                oversampling UART blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        int den;
        int div;
        den = baud * os;
        div = (clk_hz + den / 2) / den;
        return (div < 1) ? 1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_os_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os_if
//  Description : Serial line plus valid/ready word interface of the receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rx, ready,
        output data, valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        output rx, ready,
        input  data, valid, parity_err, frame_err, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running oversample tick generator with restart input.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int OS     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int              c_DIV  = uart_div(CLK_HZ, BAUD, OS);
    localparam int              c_CW   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : Oversampling UART receiver, 3-sample majority per bit, with a
//                valid/ready holding register for the received word.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int OS        = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_os_if.master io_bus
);
    localparam int              c_CW        = $clog2(OS);
    localparam logic [c_CW-1:0] c_S0        = c_CW'(OS / 2 - 1);
    localparam logic [c_CW-1:0] c_S1        = c_CW'(OS / 2);
    localparam logic [c_CW-1:0] c_DEC       = c_CW'(OS / 2 + 1);
    localparam logic [c_CW-1:0] c_END       = c_CW'(OS - 1);
    localparam int              c_IW        = $clog2(DATA_BITS);
    localparam logic [c_IW-1:0] c_LAST_BIT  = c_IW'(DATA_BITS - 1);
    localparam logic            c_LAST_STOP = 1'(STOP_BITS - 1);

    state_t               r_state, w_state_next;
    logic                 r_sync1, r_sync2, r_rx_prev;
    logic                 w_rx, w_tick, w_restart, w_dec, w_end, w_maj, w_fall, w_perr;
    logic [c_CW-1:0]      r_os_cnt;
    logic [1:0]           r_samp;
    logic [c_IW-1:0]      r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_ferr_int, r_done, r_ferr_pend;
    logic [1:0]           r_idle_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_perr, r_ferr, r_ovr;

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OS(OS)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign w_rx      = r_sync2;
    assign w_fall    = r_rx_prev & ~w_rx;
    assign w_dec     = w_tick && (r_os_cnt == c_DEC);
    assign w_end     = w_tick && (r_os_cnt == c_END);
    // Third sample is the live line value at the decision tick.
    assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
    assign w_restart = (r_state == ST_IDLE) && (w_state_next == ST_START);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_fall) w_state_next = ST_START;
            ST_START:     if (w_dec && w_maj) w_state_next = ST_IDLE;
                          else if (w_end) w_state_next = ST_DATA;
            ST_DATA:      if (w_end && (r_idx == c_LAST_BIT))
                              w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (w_end) w_state_next = ST_STOP;
            ST_STOP:      if (w_dec && (r_stop_idx == c_LAST_STOP))
                              w_state_next = (r_ferr_int || !w_maj) ? ST_WAIT_IDLE : ST_IDLE;
            ST_WAIT_IDLE: if (w_tick && w_rx && (r_idle_cnt == 2'd2)) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_os_cnt    <= '0;
            r_samp      <= '0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_ferr_int  <= 1'b0;
            r_done      <= 1'b0;
            r_ferr_pend <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            r_sync1   <= io_bus.rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            r_done    <= 1'b0;
            if ((r_state == ST_IDLE) || (w_state_next != r_state)) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= (r_os_cnt == c_END) ? '0 : r_os_cnt + c_CW'(1);
            end
            if (w_tick && (r_os_cnt == c_S0)) r_samp[0] <= w_rx;
            if (w_tick && (r_os_cnt == c_S1)) r_samp[1] <= w_rx;
            if (w_restart) begin
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
                r_ferr_int <= 1'b0;
            end
            if (r_state == ST_DATA) begin
                if (w_dec) r_shift[r_idx] <= w_maj;
                if (w_end) r_idx <= (r_idx == c_LAST_BIT) ? '0 : r_idx + c_IW'(1);
            end
            if ((r_state == ST_PARITY) && w_dec) r_par_bit <= w_maj;
            if (r_state == ST_STOP) begin
                if (w_dec && !w_maj) r_ferr_int <= 1'b1;
                // Frame completes at the final stop decision, not at bit end.
                if (w_dec && (r_stop_idx == c_LAST_STOP)) begin
                    r_done      <= 1'b1;
                    r_ferr_pend <= r_ferr_int | ~w_maj;
                end else if (w_end) begin
                    r_stop_idx <= 1'b1;
                end
            end
            if (r_state != ST_WAIT_IDLE) begin
                r_idle_cnt <= '0;
            end else if (w_tick) begin
                r_idle_cnt <= w_rx ? r_idle_cnt + 2'd1 : 2'd0;
            end
        end
    end

    always_comb begin
        w_perr = 1'b0;
        if (PARITY == PAR_EVEN) begin
            w_perr = ^{r_shift, r_par_bit};
        end else if (PARITY == PAR_ODD) begin
            w_perr = ~^{r_shift, r_par_bit};
        end
    end

    // A completion in the same cycle as an acceptance reloads rather than clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_done) begin
                if (!r_valid || io_bus.ready) begin
                    r_data  <= r_shift;
                    r_perr  <= w_perr;
                    r_ferr  <= r_ferr_pend;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && io_bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign io_bus.data       = r_data;
    assign io_bus.valid      = r_valid;
    assign io_bus.parity_err = r_perr;
    assign io_bus.frame_err  = r_ferr;
    assign io_bus.overrun    = r_ovr;
    assign io_bus.busy       = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_os
//  Description : Directed self-checking bench for uart_rx_os (8N1 and 8E1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int c_CLK_HZ = 1_600_000;
    localparam int c_BAUD   = 100_000;
    localparam int c_OS     = 16;
    localparam int c_BIT    = 16;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic tb_rx   = 1'b1;
    logic tb_sel  = 1'b0;
    logic ready_n = 1'b1;

    always #5 clk = ~clk;

    uart_rx_os_if #(.DATA_BITS(8)) if_n ();
    uart_rx_os_if #(.DATA_BITS(8)) if_e ();

    assign if_n.rx    = tb_sel ? 1'b1 : tb_rx;
    assign if_e.rx    = tb_sel ? tb_rx : 1'b1;
    assign if_n.ready = ready_n;
    assign if_e.ready = 1'b1;

    uart_rx_os #(.CLK_HZ(c_CLK_HZ), .BAUD(c_BAUD), .OS(c_OS), .DATA_BITS(8),
                 .PARITY(PAR_NONE), .STOP_BITS(1)) dut_n (
        .clk    (clk),
        .rst    (rst),
        .io_bus (if_n)
    );

    uart_rx_os #(.CLK_HZ(c_CLK_HZ), .BAUD(c_BAUD), .OS(c_OS), .DATA_BITS(8),
                 .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_e (
        .clk    (clk),
        .rst    (rst),
        .io_bus (if_e)
    );

    int         n_cnt = 0;
    int         e_cnt = 0;
    int         n_ovr = 0;
    logic [7:0] n_data = '0;
    logic [7:0] e_data = '0;
    logic       n_perr = 1'b0, n_ferr = 1'b0, e_perr = 1'b0, e_ferr = 1'b0;
    time        n_t = 0;

    // Record every accepted word and every overrun pulse.
    always @(negedge clk) begin
        #1;
        if (if_n.valid && ready_n) begin
            n_cnt  <= n_cnt + 1;
            n_data <= if_n.data;
            n_perr <= if_n.parity_err;
            n_ferr <= if_n.frame_err;
            n_t    <= $time;
        end
        if (if_n.overrun) n_ovr <= n_ovr + 1;
        if (if_e.valid) begin
            e_cnt  <= e_cnt + 1;
            e_data <= if_e.data;
            e_perr <= if_e.parity_err;
            e_ferr <= if_e.frame_err;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n * c_BIT) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        tb_rx = b;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(p);
        send_bit(stop);
    endtask

    initial begin
        int  base;
        int  ob;
        int  lat;
        time t0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(if_n.valid), 32'd0);
        chk("rst_data", 32'(if_n.data), 32'd0);
        chk("rst_busy", 32'(if_n.busy), 32'd0);
        chk("rst_flags", 32'({if_n.parity_err, if_n.frame_err, if_n.overrun}), 32'd0);
        rst = 1'b0;
        idle_bits(1);

        // 8N1 0xA5
        base = n_cnt;
        t0   = $time;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        lat = int'((n_t - t0) / 10);
        chk("a5_count", 32'(n_cnt - base), 32'd1);
        chk("a5_data", 32'(n_data), 32'hA5);
        chk("a5_flags", 32'({n_perr, n_ferr}), 32'd0);
        chk("a5_latency_in_window", 32'(lat >= 152 && lat <= 160), 32'd1);
        chk("a5_valid_drop", 32'(if_n.valid), 32'd0);
        chk("a5_busy_idle", 32'(if_n.busy), 32'd0);

        // Even parity
        tb_sel = 1'b1;
        base   = e_cnt;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        chk("par03_p0_count", 32'(e_cnt - base), 32'd1);
        chk("par03_p0_data", 32'(e_data), 32'h03);
        chk("par03_p0_perr", 32'(e_perr), 32'd0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        chk("par03_p1_data", 32'(e_data), 32'h03);
        chk("par03_p1_perr", 32'(e_perr), 32'd1);
        chk("par03_p1_ferr", 32'(e_ferr), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        chk("par07_p1_data", 32'(e_data), 32'h07);
        chk("par07_p1_perr", 32'(e_perr), 32'd0);
        chk("par_total_count", 32'(e_cnt - base), 32'd3);
        tb_sel = 1'b0;

        // False start
        base  = n_cnt;
        tb_rx = 1'b0;
        repeat (4) @(negedge clk);
        tb_rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("fstart_busy_high", 32'(if_n.busy), 32'd1);
        repeat (10) @(negedge clk);
        chk("fstart_busy_low", 32'(if_n.busy), 32'd0);
        idle_bits(1);
        chk("fstart_no_word", 32'(n_cnt - base), 32'd0);

        // Framing error followed by a long break
        base = n_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (40 * c_BIT) @(negedge clk);
        chk("brk_count", 32'(n_cnt - base), 32'd1);
        chk("brk_data", 32'(n_data), 32'h55);
        chk("brk_ferr", 32'(n_ferr), 32'd1);
        chk("brk_busy_in_break", 32'(if_n.busy), 32'd1);
        tb_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("brk_wait_idle_hold", 32'(if_n.busy), 32'd1);
        repeat (5) @(negedge clk);
        chk("brk_back_idle", 32'(if_n.busy), 32'd0);
        idle_bits(1);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        chk("post_brk_data", 32'(n_data), 32'h12);
        chk("post_brk_ferr", 32'(n_ferr), 32'd0);
        chk("post_brk_count", 32'(n_cnt - base), 32'd2);

        // Overrun with consumer stalled
        ready_n = 1'b0;
        base    = n_cnt;
        ob      = n_ovr;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        chk("ovr_first_valid", 32'(if_n.valid), 32'd1);
        chk("ovr_first_data", 32'(if_n.data), 32'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        chk("ovr_data_held", 32'(if_n.data), 32'h11);
        chk("ovr_pulses", 32'(n_ovr - ob), 32'd1);
        chk("ovr_valid_held", 32'(if_n.valid), 32'd1);
        ready_n = 1'b1;
        @(negedge clk);
        chk("ovr_accept_count", 32'(n_cnt - base), 32'd1);
        chk("ovr_accept_data", 32'(n_data), 32'h11);
        chk("ovr_valid_drop", 32'(if_n.valid), 32'd0);

        // Reset during data bit 3 of 0x7E
        base = n_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tb_rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_busy", 32'(if_n.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_data", 32'(if_n.data), 32'd0);
        chk("mid_rst_valid_busy", 32'({if_n.valid, if_n.busy}), 32'd0);
        chk("mid_rst_flags", 32'({if_n.parity_err, if_n.frame_err, if_n.overrun}), 32'd0);
        idle_bits(2);
        chk("mid_no_word", 32'(n_cnt - base), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        chk("post_rst_count", 32'(n_cnt - base), 32'd1);
        chk("post_rst_data", 32'(n_data), 32'h81);
        chk("post_rst_flags", 32'({n_perr, n_ferr}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
